// File: rtl/alu_ctrl_md.sv
// alu_ctrl_md: EX-stage ALU operation decode plus iterative multiply/divide unit
// that holds the pipeline through a stall handshake until the result is ready.
// Optional macro ALU_CTRL_MD_FASTMUL_EN: single-cycle multiplier (division stays iterative).
module alu_ctrl_md #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   input  logic            flush,
   input  logic [1:0]      ALUOp,
   input  logic [6:0]      Funct7,
   input  logic [2:0]      Funct3,
   input  logic            IsRType,
   input  logic            EhJAL,
   input  logic            EhJALR,
   input  logic [XLEN-1:0] SrcA,
   input  logic [XLEN-1:0] SrcB,
   output logic [3:0]      Operation,
   output logic            md_sel,
   output logic [XLEN-1:0] md_result,
   output logic            md_done,
   output logic            stall
);

   localparam int unsigned CNT_W = $clog2(XLEN) + 1;
   localparam int unsigned ACC_W = 2 * XLEN;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   op_q, op_d;       // multiplicand (MUL) or divisor magnitude (DIV)
   logic [ACC_W-1:0]  acc_q, acc_d;     // {high/remainder, multiplier/quotient}
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        f3_q, f3_d;
   logic              neg_q, neg_d;     // product / quotient sign
   logic              nega_q, nega_d;   // remainder sign (dividend sign)
   logic [XLEN-1:0]   res_q, res_d;

   logic              is_mop_c, accept_c;
   logic              sgn_a_c, sgn_b_c, neg_a_c, neg_b_c, div_zero_c, div_ovf_c;
   logic [XLEN-1:0]   mag_a_c, mag_b_c;
   logic [ACC_W-1:0]  mul_fin_c, mul_sgn_c, div_fin_c;
   logic [XLEN:0]     div_shift_c, div_diff_c;
   logic [XLEN-1:0]   quo_c, rem_c, mul_res_c, div_res_c;
   logic              mul_last_c, cnt_last_c;

   assign is_mop_c = (ALUOp == 2'b10) && IsRType && (Funct7 == 7'b0000001);
   assign accept_c = reset_n && (state_q == S_IDLE) && in_valid && is_mop_c && !flush;

   // Base ALU operation decode; M-ops report ADD as a don't-care
   always_comb begin
      Operation = 4'b0010;
      if (EhJALR) begin
         Operation = 4'b0011;
      end else if (EhJAL) begin
         Operation = 4'b0000;
      end else begin
         case (ALUOp)
            2'b00: Operation = 4'b0010;
            2'b01: Operation = Funct3[2] ? 4'b1001 : 4'b1000;
            2'b10: begin
               if (!is_mop_c) begin
                  case (Funct3)
                     3'b000:         Operation = (IsRType && Funct7[5]) ? 4'b0011 : 4'b0010;
                     3'b001:         Operation = 4'b0100;
                     3'b010, 3'b011: Operation = 4'b1100;
                     3'b100:         Operation = 4'b1010;
                     3'b101:         Operation = Funct7[5] ? 4'b0111 : 4'b0101;
                     3'b110:         Operation = 4'b0001;
                     default:        Operation = 4'b0000;
                  endcase
               end
            end
            default: Operation = 4'b0000;
         endcase
      end
   end

   // Operand signedness, magnitudes and division special cases at accept
   always_comb begin
      sgn_a_c    = (Funct3 == 3'b001) || (Funct3 == 3'b010) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
      sgn_b_c    = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
      neg_a_c    = sgn_a_c && SrcA[XLEN-1];
      neg_b_c    = sgn_b_c && SrcB[XLEN-1];
      mag_a_c    = neg_a_c ? (~SrcA + XLEN'(1)) : SrcA;
      mag_b_c    = neg_b_c ? (~SrcB + XLEN'(1)) : SrcB;
      div_zero_c = (SrcB == '0);
      div_ovf_c  = sgn_b_c && (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (SrcB == '1);
   end

`ifdef ALU_CTRL_MD_FASTMUL_EN
   // Full product in one step from the latched magnitudes
   assign mul_fin_c  = ACC_W'(op_q) * ACC_W'(acc_q[XLEN-1:0]);
   assign mul_last_c = 1'b1;
`else
   logic [XLEN:0] mul_sum_c;
   // One shift-add step: conditionally add multiplicand to high half, then shift right
   always_comb begin
      mul_sum_c = {1'b0, acc_q[ACC_W-1:XLEN]} + (acc_q[0] ? {1'b0, op_q} : {(XLEN+1){1'b0}});
      mul_fin_c = {mul_sum_c, acc_q[XLEN-1:1]};
   end
   assign mul_last_c = cnt_last_c;
`endif

   assign cnt_last_c = (cnt_q == CNT_W'(XLEN - 1));

   // One restoring-division step and signed result selection for both units
   always_comb begin
      div_shift_c = {acc_q[ACC_W-1:XLEN], acc_q[XLEN-1]};
      div_diff_c  = div_shift_c - {1'b0, op_q};
      div_fin_c   = div_diff_c[XLEN] ? {div_shift_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                     : {div_diff_c[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
      quo_c       = div_fin_c[XLEN-1:0];
      rem_c       = div_fin_c[ACC_W-1:XLEN];
      div_res_c   = f3_q[1] ? (nega_q ? (~rem_c + XLEN'(1)) : rem_c)
                            : (neg_q  ? (~quo_c + XLEN'(1)) : quo_c);
      mul_sgn_c   = neg_q ? (~mul_fin_c + ACC_W'(1)) : mul_fin_c;
      mul_res_c   = (f3_q == 3'b000) ? mul_sgn_c[XLEN-1:0] : mul_sgn_c[ACC_W-1:XLEN];
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      f3_d    = f3_q;
      neg_d   = neg_q;
      nega_d  = nega_q;
      res_d   = res_q;
      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               f3_d   = Funct3;
               neg_d  = neg_a_c ^ neg_b_c;
               nega_d = neg_a_c;
               cnt_d  = '0;
               op_d   = Funct3[2] ? mag_b_c : mag_a_c;
               acc_d  = {{XLEN{1'b0}}, (Funct3[2] ? mag_a_c : mag_b_c)};
               if (Funct3[2] && div_zero_c) begin
                  res_d   = Funct3[1] ? SrcA : '1;
                  state_d = S_DONE;
               end else if (Funct3[2] && div_ovf_c) begin
                  res_d   = Funct3[1] ? '0 : SrcA;
                  state_d = S_DONE;
               end else begin
                  state_d = Funct3[2] ? S_DIV : S_MUL;
               end
            end
         end
         S_MUL: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d = mul_fin_c;
               cnt_d = cnt_q + CNT_W'(1);
               if (mul_last_c) begin
                  res_d   = mul_res_c;
                  state_d = S_DONE;
               end
            end
         end
         S_DIV: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d = div_fin_c;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_last_c) begin
                  res_d   = div_res_c;
                  state_d = S_DONE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         f3_q    <= '0;
         neg_q   <= 1'b0;
         nega_q  <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         f3_q    <= f3_d;
         neg_q   <= neg_d;
         nega_q  <= nega_d;
         res_q   <= res_d;
      end
   end

   // Handshake outputs; flush drops stall and suppresses completion in the same cycle
   assign stall     = accept_c || (((state_q == S_MUL) || (state_q == S_DIV)) && !flush);
   assign md_done   = (state_q == S_DONE) && !flush;
   assign md_sel    = (state_q == S_DONE) && !flush;
   assign md_result = res_q;

endmodule

// File: tb/tb_alu_ctrl_md.sv
// tb_alu_ctrl_md: decode vector table, multiply/divide scoreboard and abort sequences.
module tb_alu_ctrl_md;

   localparam int unsigned XLEN = 32;
`ifdef ALU_CTRL_MD_FASTMUL_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = XLEN + 1;
`endif
   localparam int DIV_LAT = XLEN + 1;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            in_valid, flush;
   logic [1:0]      ALUOp;
   logic [6:0]      Funct7;
   logic [2:0]      Funct3;
   logic            IsRType, EhJAL, EhJALR;
   logic [XLEN-1:0] SrcA, SrcB;
   logic [3:0]      Operation;
   logic            md_sel, md_done, stall;
   logic [XLEN-1:0] md_result;

   alu_ctrl_md #(.XLEN(XLEN)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .flush(flush),
      .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .IsRType(IsRType),
      .EhJAL(EhJAL), .EhJALR(EhJALR), .SrcA(SrcA), .SrcB(SrcB),
      .Operation(Operation), .md_sel(md_sel), .md_result(md_result),
      .md_done(md_done), .stall(stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] aluop; logic [6:0] f7; logic [2:0] f3;
      logic isr; logic jal; logic jalr; logic [3:0] op;
   } dec_vec_t;

   typedef struct {
      logic [2:0] f3; logic [XLEN-1:0] a; logic [XLEN-1:0] b;
      logic [XLEN-1:0] res; int lat; string nm;
   } md_vec_t;

   int              n_cmp = 0;
   int              n_err = 0;
   logic [XLEN-1:0] exp_q[$];
   logic [XLEN-1:0] last_res;
   dec_vec_t        dv[17];
   md_vec_t         mv[19];

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_mop(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = f3; IsRType = 1'b1;
      EhJAL = 1'b0; EhJALR = 1'b0; SrcA = a; SrcB = b;
   endtask

   // Launch one M-op, keep it valid through DONE, then check completion and hold
   task automatic run_mop(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] exp_res, input int exp_lat, input string nm);
      int k;
      int nst;
      logic seen;
      logic [XLEN-1:0] e;
      exp_q.push_back(exp_res);
      drive_mop(f3, a, b);
      in_valid = 1'b1;
      k = 0; nst = 0; seen = 1'b0;
      while (!seen && k <= 3 * XLEN) begin
         #4;
         if (k == 0) begin
            chk({nm, " op"}, 64'(Operation), 64'(4'b0010));
            chk({nm, " accept stall"}, 64'(stall), 64'(1'b1));
         end
         if (md_done) begin
            seen = 1'b1;
         end else begin
            if (stall) nst++;
            tick();
            k++;
         end
      end
      chk({nm, " done seen"}, 64'(seen), 64'(1'b1));
      e = exp_q.pop_front();
      if (seen) begin
         chk({nm, " result"}, 64'(md_result), 64'(e));
         chk({nm, " md_sel"}, 64'(md_sel), 64'(1'b1));
         chk({nm, " done stall"}, 64'(stall), 64'(1'b0));
         chk({nm, " latency"}, 64'(k), 64'(exp_lat));
         chk({nm, " stall cycles"}, 64'(nst), 64'(exp_lat));
         tick();
         in_valid = 1'b0;
         #4;
         chk({nm, " idle stall"}, 64'(stall), 64'(1'b0));
         chk({nm, " idle done"}, 64'(md_done), 64'(1'b0));
         chk({nm, " hold"}, 64'(md_result), 64'(e));
         last_res = e;
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic no_done_window(input string nm);
      int nd;
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         #4;
         if (md_done || stall) nd++;
         tick();
      end
      chk({nm, " quiet"}, 64'(nd), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      dv[0]  = '{2'b00, 7'h00, 3'b010, 1'b0, 1'b0, 1'b0, 4'b0010};
      dv[1]  = '{2'b01, 7'h00, 3'b000, 1'b0, 1'b0, 1'b0, 4'b1000};
      dv[2]  = '{2'b01, 7'h00, 3'b001, 1'b0, 1'b0, 1'b0, 4'b1000};
      dv[3]  = '{2'b01, 7'h00, 3'b100, 1'b0, 1'b0, 1'b0, 4'b1001};
      dv[4]  = '{2'b01, 7'h00, 3'b101, 1'b0, 1'b0, 1'b0, 4'b1001};
      dv[5]  = '{2'b10, 7'h00, 3'b000, 1'b1, 1'b0, 1'b0, 4'b0010};
      dv[6]  = '{2'b10, 7'h20, 3'b000, 1'b1, 1'b0, 1'b0, 4'b0011};
      dv[7]  = '{2'b10, 7'h20, 3'b000, 1'b0, 1'b0, 1'b0, 4'b0010};
      dv[8]  = '{2'b10, 7'h00, 3'b001, 1'b1, 1'b0, 1'b0, 4'b0100};
      dv[9]  = '{2'b10, 7'h00, 3'b101, 1'b1, 1'b0, 1'b0, 4'b0101};
      dv[10] = '{2'b10, 7'h20, 3'b101, 1'b1, 1'b0, 1'b0, 4'b0111};
      dv[11] = '{2'b10, 7'h00, 3'b100, 1'b1, 1'b0, 1'b0, 4'b1010};
      dv[12] = '{2'b10, 7'h00, 3'b010, 1'b1, 1'b0, 1'b0, 4'b1100};
      dv[13] = '{2'b10, 7'h00, 3'b110, 1'b1, 1'b0, 1'b0, 4'b0001};
      dv[14] = '{2'b10, 7'h00, 3'b111, 1'b1, 1'b0, 1'b0, 4'b0000};
      dv[15] = '{2'b11, 7'h00, 3'b000, 1'b0, 1'b1, 1'b0, 4'b0000};
      dv[16] = '{2'b00, 7'h00, 3'b000, 1'b0, 1'b0, 1'b1, 4'b0011};

      mv[0]  = '{3'b100, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFF2, DIV_LAT, "div -100/7"};
      mv[1]  = '{3'b110, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, DIV_LAT, "rem -100/7"};
      mv[2]  = '{3'b100, 32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2, DIV_LAT, "div 100/-7"};
      mv[3]  = '{3'b110, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, DIV_LAT, "rem 100/-7"};
      mv[4]  = '{3'b101, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, DIV_LAT, "divu"};
      mv[5]  = '{3'b111, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, DIV_LAT, "remu"};
      mv[6]  = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, DIV_LAT, "divu no ovf"};
      mv[7]  = '{3'b101, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1, "divu by 0"};
      mv[8]  = '{3'b111, 32'h00001234, 32'h00000000, 32'h00001234, 1, "remu by 0"};
      mv[9]  = '{3'b100, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, 1, "div by 0"};
      mv[10] = '{3'b110, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 1, "rem by 0"};
      mv[11] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div ovf"};
      mv[12] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, "rem ovf"};
      mv[13] = '{3'b001, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, MUL_LAT, "mulh -2*3"};
      mv[14] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, "mulhu"};
      mv[15] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, MUL_LAT, "mul"};
      mv[16] = '{3'b000, 32'h12345678, 32'h00000010, 32'h23456780, MUL_LAT, "mul low"};
      mv[17] = '{3'b010, 32'h00000002, 32'hFFFFFFFF, 32'h00000001, MUL_LAT, "mulhsu"};
      mv[18] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT, "mulh min*min"};

      reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
      ALUOp = 2'b00; Funct7 = 7'h00; Funct3 = 3'b000; IsRType = 1'b0;
      EhJAL = 1'b0; EhJALR = 1'b0; SrcA = '0; SrcB = '0;
      last_res = '0;
      #12;
      chk("reset stall", 64'(stall), 64'(1'b0));
      chk("reset md_done", 64'(md_done), 64'(1'b0));
      chk("reset md_sel", 64'(md_sel), 64'(1'b0));
      chk("reset md_result", 64'(md_result), 64'(0));
      reset_n = 1'b1;
      tick();

      // Base decode: same-cycle Operation, never stalls
      for (int i = 0; i < 17; i++) begin
         ALUOp = dv[i].aluop; Funct7 = dv[i].f7; Funct3 = dv[i].f3;
         IsRType = dv[i].isr; EhJAL = dv[i].jal; EhJALR = dv[i].jalr;
         in_valid = 1'b1;
         #4;
         chk($sformatf("decode %0d op", i), 64'(Operation), 64'(dv[i].op));
         chk($sformatf("decode %0d stall", i), 64'(stall), 64'(1'b0));
         tick();
      end
      in_valid = 1'b0; EhJAL = 1'b0; EhJALR = 1'b0;

      for (int i = 0; i < 19; i++)
         run_mop(mv[i].f3, mv[i].a, mv[i].b, mv[i].res, mv[i].lat, mv[i].nm);

      // flush wins over in_valid in IDLE
      drive_mop(3'b100, 32'h7, 32'h2);
      in_valid = 1'b1; flush = 1'b1;
      #4;
      chk("idle flush stall", 64'(stall), 64'(1'b0));
      tick();
      in_valid = 1'b0; flush = 1'b0;
      #4;
      chk("idle flush no launch", 64'(stall), 64'(1'b0));
      tick();

      // flush at T10 of a DIV
      drive_mop(3'b100, 32'hFFFFFF9C, 32'h7);
      in_valid = 1'b1;
      #4;
      chk("flush div accept stall", 64'(stall), 64'(1'b1));
      tick();
      repeat (9) tick();
      #2;
      chk("flush div T10 stall before", 64'(stall), 64'(1'b1));
      flush = 1'b1;
      #2;
      chk("flush div T10 stall", 64'(stall), 64'(1'b0));
      chk("flush div T10 done", 64'(md_done), 64'(1'b0));
      tick();
      flush = 1'b0; in_valid = 1'b0;
      #4;
      chk("flush div T11 stall", 64'(stall), 64'(1'b0));
      chk("flush div hold result", 64'(md_result), 64'(last_res));
      tick();
      no_done_window("after flush");
      run_mop(3'b101, 32'h000003E8, 32'h3, 32'h0000014D, DIV_LAT, "divu after flush");

      // reset at T5 of a DIVU
      drive_mop(3'b101, 32'hFFFFFFFF, 32'h3);
      in_valid = 1'b1;
      tick();
      repeat (4) tick();
      reset_n = 1'b0;
      #1;
      chk("mid reset stall", 64'(stall), 64'(1'b0));
      chk("mid reset md_done", 64'(md_done), 64'(1'b0));
      chk("mid reset md_sel", 64'(md_sel), 64'(1'b0));
      chk("mid reset md_result", 64'(md_result), 64'(0));
      in_valid = 1'b0;
      #2;
      reset_n = 1'b1;
      tick();
      no_done_window("after reset");
      run_mop(3'b101, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, DIV_LAT, "divu after reset");

      // back-to-back: next op presented during DONE launches on the following IDLE cycle
      exp_q.push_back(32'h00001234);
      exp_q.push_back(32'hFFFFFFFF);
      drive_mop(3'b111, 32'h1234, 32'h0);
      in_valid = 1'b1;
      #4;
      chk("b2b first stall", 64'(stall), 64'(1'b1));
      tick();
      drive_mop(3'b101, 32'h55, 32'h0);
      #4;
      chk("b2b first done", 64'(md_done), 64'(1'b1));
      chk("b2b first result", 64'(md_result), 64'(exp_q.pop_front()));
      chk("b2b done ignores valid", 64'(stall), 64'(1'b0));
      tick();
      #4;
      chk("b2b second stall", 64'(stall), 64'(1'b1));
      chk("b2b second not done", 64'(md_done), 64'(1'b0));
      tick();
      in_valid = 1'b0;
      #4;
      chk("b2b second done", 64'(md_done), 64'(1'b1));
      chk("b2b second result", 64'(md_result), 64'(exp_q.pop_front()));
      tick();

      // flush in DONE suppresses completion
      drive_mop(3'b100, 32'h9, 32'h0);
      in_valid = 1'b1;
      #4;
      chk("done flush accept", 64'(stall), 64'(1'b1));
      tick();
      flush = 1'b1;
      #4;
      chk("done flush md_done", 64'(md_done), 64'(1'b0));
      chk("done flush md_sel", 64'(md_sel), 64'(1'b0));
      chk("done flush stall", 64'(stall), 64'(1'b0));
      tick();
      flush = 1'b0; in_valid = 1'b0;
      #4;
      chk("done flush idle", 64'(stall | md_done), 64'(1'b0));
      tick();

      chk("scoreboard empty", 64'(exp_q.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_ctrl_md.md
# alu_ctrl_md

Sequential successor to the EX-stage ALU controller. It decodes ALUOp/Funct3/Funct7 into the 4-bit ALU `Operation` code, and adds RV32M/RV64M-style multiply/divide execution with a pipeline stall handshake. The base ALU path stays single-cycle combinational. Multiply/divide ops run in an internal iterative unit while the block holds the pipeline via `stall`, then return the result through `md_result`/`md_sel`.

## Interface
- `XLEN`, 32, operand/result width; even, ≥ 8
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  a valid instruction is present in EX
- `flush`  in  1  kill the EX instruction; aborts any M-op in progress
- `ALUOp`  in  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI
- `Funct7`  in  7  instr[31:25]
- `Funct3`  in  3  instr[14:12]
- `IsRType`  in  1  opcode is OP (R-type); qualifies M decode
- `EhJAL`, `EhJALR`  in  1 each  jump flags
- `SrcA`, `SrcB`  in  XLEN  forwarded operands (rs1, rs2)
- `Operation`  out  4  ALU op code (combinational)
- `md_sel`  out  1  writeback mux selects `md_result`
- `md_result`  out  XLEN  multiply/divide result
- `md_done`  out  1  one-cycle pulse, result valid
- `stall`  out  1  hold PC, IF/ID and ID/EX

## Operation
- Base decode is combinational and unchanged in encoding:
  - AND 0000, OR 0001, ADD 0010, SUB 0011, SLL 0100, SRL 0101, SRA 0111, XOR 1010, SLT 1100.
  - BEQ/BNE 1000, BLT/BGE 1001.
  - LW/SW/AUIPC 0010, JALR 0011, JAL/LUI 0000.
- M-op = `ALUOp==10 && IsRType && Funct7==0000001`. For an M-op, `Operation`=0010 (don't care).
- Funct3 for M-ops: 000 MUL (low XLEN bits), 001 MULH (s×s high), 010 MULHSU (s×u high), 011 MULHU (u×u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - On `in_valid && M-op && !flush`, latch SrcA, SrcB and Funct3.
  - Assert `stall` combinationally in that same cycle.
  - Go to MUL (Funct3[2]=0) or DIV (Funct3[2]=1).
- Division special cases are resolved at accept and go straight to DONE:
  - Divide by zero: quotient all-ones, remainder = dividend (signed and unsigned).
  - Signed overflow (−2^(XLEN−1) / −1): quotient = dividend, remainder 0.
- MUL: iterative shift-add over operand magnitudes, 2·XLEN-bit accumulator, XLEN cycles. Sign is corrected at the end; MULHSU treats only SrcA as signed.
- DIV: restoring shift-subtract on magnitudes, XLEN cycles.
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
- Iteration counter is $clog2(XLEN)+1 bits; it leaves the iterate state when it reaches XLEN−1.
- DONE:
  - `md_result` holds the final value; `md_sel`=1, `md_done`=1, `stall`=0. The held instruction advances.
  - Return to IDLE. `in_valid` is ignored in DONE (no relaunch of the same instruction).
- Back-to-back M-ops: the next M-op is accepted in IDLE on the cycle after DONE.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE. `stall`, `md_sel`, `md_done` = 0; `md_result` = 0; accumulators cleared.
- Iterative op: accept cycle T0, iterate T1..T_XLEN, DONE at T_XLEN+1.
  - `stall` is high for XLEN+1 cycles.
  - `md_done` pulses at T_XLEN+1.
- Special-case division: DONE at T1; `stall` high for 1 cycle.
- `flush` in MUL/DIV: IDLE next cycle. `stall` drops the same cycle (combinational from `flush`); no `md_done`. `flush` has priority over `in_valid`.
- `flush` in DONE: `md_done`/`md_sel` are suppressed that cycle.
- `md_result` holds its last value after DONE until the next DONE.
- Reset mid-operation: immediate IDLE, outputs at reset values, no `md_done`.

## Configuration
- `ALU_CTRL_MD_FASTMUL_EN` defined: MUL-class ops compute the full 2·XLEN product in one cycle from the latched operands. MUL state lasts one cycle; DONE at T2; `stall` high 2 cycles.
- Undefined: the iterative multiplier described above is used (XLEN cycles). Division is iterative in both builds.

## Test plan
- Base decode: ALUOp=10, Funct3=000, Funct7=0100000, IsRType=1 → `Operation`=0011 in the same cycle, `stall`=0.
- DIV, XLEN=32: SrcA=−100, SrcB=7 → `stall` high 33 cycles; `md_done` at T33 with `md_result`=−14. REM with the same operands → −2.
- DIVU SrcB=0, SrcA=0x1234 → `md_result`=0xFFFFFFFF at T1. REMU with the same operands → 0x1234. `stall` 1 cycle.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at T1; REM → 0.
- MULH −2 × 3 → 0xFFFFFFFF; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MUL → 0x00000001.
  - Without the macro, DONE at T33.
  - With `ALU_CTRL_MD_FASTMUL_EN`, DONE at T2.
- Abort cases:
  - `flush` at T10 of a DIV → `stall`=0 in that cycle, no `md_done`, IDLE at T11.
  - `reset_n` low at T5 → all outputs 0 immediately.
  - A new DIVU after either abort completes correctly.
